// File: rtl/mem_bus.sv
// Word-level memory bus controller: routes aligned word requests to on-chip RAM
// or to a stalling req/ack I/O bus, returning read data one cycle after retirement.
module mem_bus #(
  parameter int IO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [29:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_err,
  output logic [29:0] ram_addr,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        io_req,
  output logic [3:0]  io_we,
  output logic [29:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack
);

  localparam int CNT_W = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IO_WAIT = 2'd1,
    IO_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [31:0]        io_rdata_r;
  logic               src_io_r;
  logic               present_s;
  logic               io_access_s;
  logic               timeout_hit_s;

  assign present_s     = re | (we != 4'b0000);
  assign io_access_s   = present_s & addr[29];
  assign timeout_hit_s = (IO_TIMEOUT != 0) && (cnt_r == CNT_W'(IO_TIMEOUT - 1));

  assign ram_addr  = addr;
  assign ram_wdata = wdata;
  assign ram_we    = (!reset && !addr[29]) ? we : 4'b0000;
  assign rdata     = src_io_r ? io_rdata_r : ram_rdata;

  // Next-state and stall decode; reset forces the pipeline free.
  always_comb begin
    state_nxt_s = state_r;
    stall       = 1'b0;
    case (state_r)
      IDLE: begin
        if (io_access_s) begin
          stall       = 1'b1;
          state_nxt_s = IO_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IO_WAIT: begin
        stall = 1'b1;
        if (io_ack || timeout_hit_s) begin
          state_nxt_s = IO_DONE;
        end else begin
          state_nxt_s = IO_WAIT;
        end
      end
      IO_DONE: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    if (reset) begin
      stall = 1'b0;
    end else begin
      stall = stall;
    end
  end

  // State register, I/O request registers, timeout counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      io_req     <= 1'b0;
      io_we      <= 4'b0000;
      io_addr    <= 30'd0;
      io_wdata   <= 32'd0;
      io_rdata_r <= 32'd0;
      src_io_r   <= 1'b0;
      cnt_r      <= '0;
      bus_err    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (io_access_s) begin
            io_req   <= 1'b1;
            io_addr  <= addr;
            io_we    <= we;
            io_wdata <= wdata;
            cnt_r    <= '0;
          end else begin
            src_io_r <= 1'b0;
          end
        end
        IO_WAIT: begin
          // Ack has priority over an expiry in the same cycle.
          if (io_ack) begin
            io_rdata_r <= io_rdata;
            io_req     <= 1'b0;
          end else if (timeout_hit_s) begin
            io_rdata_r <= 32'hFFFF_FFFF;
            io_req     <= 1'b0;
            bus_err    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        IO_DONE: src_io_r <= 1'b1;
        default: src_io_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mem_bus.md
# mem_bus

Word-level memory bus controller sitting directly downstream of the load/store alignment stage. It takes the aligned word request (read enable, 4-bit byte write enables, 30-bit word address, write data), decodes the address into on-chip RAM or the external I/O bus, and returns read data one cycle after the request retires, as the alignment stage's registered read path requires. RAM accesses never stall. I/O accesses run a registered req/ack handshake and stall the pipeline until the slave acknowledges or a timeout fires.

## Interface
- `IO_TIMEOUT`, default 255: maximum cycles `io_req` stays high without `io_ack`; 0 disables the timeout.
- `clk  in  1`: the single clock; all state updates on rising edge.
- `reset  in  1`: synchronous, active-high.
- `re  in  1`: read request, word address `addr`.
- `we  in  4`: byte write enables; nonzero means write.
- `addr  in  30`: word address; `addr[29]`=0 selects RAM, 1 selects I/O.
- `wdata  in  32`: write data, already lane-aligned.
- `rdata  out  32`: read data, valid the cycle after the request retires.
- `stall  out  1`: pipeline must hold `re/we/addr/wdata` stable while high.
- `bus_err  out  1`: sticky, set on I/O timeout.
- `ram_addr  out  30`, `ram_we  out  4`, `ram_wdata  out  32`, `ram_rdata  in  32`: synchronous RAM port, 1-cycle read latency.
- `io_req  out  1`, `io_we  out  4`, `io_addr  out  30`, `io_wdata  out  32`: registered I/O request.
- `io_rdata  in  32`, `io_ack  in  1`: I/O response; transfer completes on `io_req & io_ack`.

## Operation
- Request present = `re | (we != 0)`. RAM request = present & `!addr[29]`; I/O request = present & `addr[29]`.
- RAM path: `ram_addr=addr`, `ram_wdata=wdata`, `ram_we = we` when `!addr[29]`, else 0. No stall; request retires in the cycle it is presented.
- FSM states IDLE, IO_WAIT, IO_DONE:
  - IDLE: I/O request -> `stall=1`. Register `io_addr/io_we/io_wdata` from inputs, set `io_req=1`, clear timeout counter, go to IO_WAIT. `io_ack` is ignored in IDLE.
  - IO_WAIT: `stall=1`, `io_req` held, I/O outputs frozen. On `io_ack`: capture `io_rdata` into `io_rdata_q`, drop `io_req`, go to IO_DONE. Otherwise increment counter. When counter == `IO_TIMEOUT-1` with no ack: drop `io_req`, `io_rdata_q=32'hFFFF_FFFF`, set `bus_err`, go to IO_DONE. If ack and expiry coincide, ack wins and `bus_err` is unchanged.
  - IO_DONE: `stall=0`. The held request retires this cycle and is not re-issued. Go to IDLE unconditionally.
- Retirement records the source in `src_q`: RAM when a RAM request or no request retires, I/O on leaving IO_DONE. Next cycle, `rdata = src_q ? io_rdata_q : ram_rdata`.
- `bus_err` clears only on reset.

## Timing
- Reset (synchronous): state IDLE, `io_req=0`, `io_we=0`, `io_addr=0`, `io_wdata=0`, `io_rdata_q=0`, `src_q`=RAM, counter 0, `bus_err=0`. While `reset` is high, `stall=0` and `ram_we=0`. Reset mid-IO_WAIT abandons the transfer; a late `io_ack` then lands in IDLE and is ignored.
- RAM read: request in cycle N, `rdata` valid in N+1. Back-to-back RAM accesses are allowed every cycle.
- I/O access with ack at the first opportunity:
  - cycle N: IDLE, `stall=1`.
  - N+1: IO_WAIT, `io_req=1`, ack.
  - N+2: IO_DONE, `stall=0`, request retires.
  - N+3: `rdata` valid.
  - Minimum 2 stall cycles.
- Timeout: `io_req` is high for exactly `IO_TIMEOUT` cycles, then IO_DONE follows.
- `stall` is combinational from state and inputs. All `io_*` outputs are registered.
- I/O writes follow the same handshake; `rdata` after an I/O write is don't-care.

## Test plan
- RAM write then read: `we=4'b0011`, `addr=5`, `wdata=32'h0000BEEF`, then `re`, `addr=5` with RAM model -> `ram_we=4'b0011` with `stall=0` throughout; `rdata=32'h????BEEF` (low half `BEEF`) one cycle after the read.
- I/O read, ack on first IO_WAIT cycle: `re`, `addr=30'h2000_0004`, `io_rdata=32'h12345678`:
  - `stall` high exactly 2 cycles.
  - `io_req` high 1 cycle with `io_addr=30'h2000_0004`.
  - `rdata=32'h12345678` at N+3.
- I/O write, ack after 5 cycles: `we=4'b1111`, `wdata=32'hA5A5A5A5` -> `io_we=4'hF`, `io_wdata=32'hA5A5A5A5` stable for all 5 req cycles; stall lasts 6 cycles; no RAM write.
- Timeout with `IO_TIMEOUT=4`, no ack -> `io_req` high 4 cycles, `rdata=32'hFFFFFFFF`, `bus_err=1` and held through further RAM accesses until reset.
- Ack on the expiry cycle with `IO_TIMEOUT=4`, ack in the 4th req cycle -> `rdata=io_rdata`, `bus_err=0`.
- Reset asserted in IO_WAIT, then a stray `io_ack` -> `io_req=0`, `stall=0`, state IDLE, ack ignored; the next RAM read returns `ram_rdata`.
